// File: rtl/imm_pkg.sv
// imm_pkg: immediate format encodings, counter width and FIFO entry type
package imm_pkg;
  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_res_t;
  // true when v[31:lsb] are all equal, i.e. v is a sign extension from bit lsb
  function automatic logic fits(input logic [31:0] v, input int unsigned lsb);
    logic signed [31:0] s;
    s = $signed(v) >>> lsb;
    return s == '0 || s == '1;
  endfunction
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: request/result handshake bundle of the immediate encoder
interface imm_encoder_if;
  import imm_pkg::*;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  imm_src_e    in_imm_src;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  modport master (
    output in_valid, in_imm, in_imm_src, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
  modport slave (
    input  in_valid, in_imm, in_imm_src, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: places an immediate into its instruction format and flags out-of-range values
module imm_pack
  import imm_pkg::*;
(
  input  logic [31:0] imm_i,
  input  imm_src_e    src_i,
  input  logic [31:0] base_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  always_comb begin
    instr_o = src_i == IMM_I ? {imm_i[11:0], base_i[19:0]} :
              src_i == IMM_S ? {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]} :
              src_i == IMM_B ? {imm_i[12], imm_i[10:5], base_i[24:12], imm_i[4:1], imm_i[11], base_i[6:0]} :
                               {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], base_i[11:0]};
    err_o = src_i == IMM_B ? !fits(imm_i, 12) || imm_i[0] :
            src_i == IMM_J ? !fits(imm_i, 20) || imm_i[0] :
                             !fits(imm_i, 11);
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: encodes immediates into instructions through a 2-entry result FIFO with counters
module imm_encoder
  import imm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  imm_encoder_if.slave     bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  enc_res_t         res;
  enc_res_t         mem_q [2];
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] enc_q, enc_d, err_q, err_d;
  logic             push, pop;
  imm_pack u_pack (
    .imm_i   (bus.in_imm),
    .src_i   (bus.in_imm_src),
    .base_i  (bus.in_base),
    .instr_o (res.instr),
    .err_o   (res.err)
  );
  assign bus.in_ready  = count_q != 2'd2;
  assign bus.out_valid = count_q != 2'd0;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_err   = mem_q[rd_ptr_q].err;
  assign enc_count     = enc_q;
  assign err_count     = err_q;
  always_comb begin
    push     = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    count_d  = count_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    enc_d    = cnt_clr ? '0 : enc_q + CNT_W'(push && enc_q != '1);
    err_d    = cnt_clr ? '0 : err_q + CNT_W'(push && res.err && err_q != '1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      enc_q    <= '0;
      err_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= res;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enc_q    <= enc_d;
      err_q    <= err_d;
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed checks of packing, range errors, FIFO handshake, counters and reset
module tb_imm_encoder;
  import imm_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] enc_count, err_count;
  int          checks = 0;
  int          failures = 0;
  imm_encoder_if bus();
  imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .enc_count (enc_count),
    .err_count (err_count)
  );
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] base, input logic [31:0] imm, input imm_src_e src);
    @(negedge clk);
    bus.in_base = base;
    bus.in_imm = imm;
    bus.in_imm_src = src;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_instr !== 32'h0 || bus.out_err !== 1'b0) begin failures++; $display("FAIL rst_out got=%h/%b exp=0/0", bus.out_instr, bus.out_err); end
    checks++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin failures++; $display("FAIL rst_counts got=%h/%h exp=0/0", enc_count, err_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_i_format();
    clear();
    send(32'h00000013, 32'hFFFFFFFF, IMM_I);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF00013 || bus.out_err !== 1'b0) begin failures++; $display("FAIL i_fmt got=%b/%h/%b exp=1/fff00013/0", bus.out_valid, bus.out_instr, bus.out_err); end
    checks++; if (enc_count !== 16'd1 || err_count !== 16'd0) begin failures++; $display("FAIL i_counts got=%0d/%0d exp=1/0", enc_count, err_count); end
    send(32'h00000013, 32'hFFFFF800, IMM_I);
    checks++; if (bus.out_instr !== 32'h80000013 || bus.out_err !== 1'b0) begin failures++; $display("FAIL i_min got=%h/%b exp=80000013/0", bus.out_instr, bus.out_err); end
    send(32'h00000013, 32'h00000800, IMM_I);
    checks++; if (bus.out_instr !== 32'h80000013 || bus.out_err !== 1'b1) begin failures++; $display("FAIL i_over got=%h/%b exp=80000013/1", bus.out_instr, bus.out_err); end
    checks++; if (enc_count !== 16'd3 || err_count !== 16'd1) begin failures++; $display("FAIL i_counts2 got=%0d/%0d exp=3/1", enc_count, err_count); end
  endtask

  task automatic test_s_format();
    send(32'h00002023, 32'h000007FF, IMM_S);
    checks++; if (bus.out_instr !== 32'h7E002FA3 || bus.out_err !== 1'b0) begin failures++; $display("FAIL s_fmt got=%h/%b exp=7e002fa3/0", bus.out_instr, bus.out_err); end
  endtask

  task automatic test_b_format();
    clear();
    send(32'h00000063, 32'h00000003, IMM_B);
    checks++; if (bus.out_instr !== 32'h00000163 || bus.out_err !== 1'b1) begin failures++; $display("FAIL b_odd got=%h/%b exp=00000163/1", bus.out_instr, bus.out_err); end
    checks++; if (err_count !== 16'd1) begin failures++; $display("FAIL b_err_count got=%0d exp=1", err_count); end
    send(32'h00000063, 32'h00001000, IMM_B);
    checks++; if (bus.out_instr !== 32'h80000063 || bus.out_err !== 1'b1) begin failures++; $display("FAIL b_over got=%h/%b exp=80000063/1", bus.out_instr, bus.out_err); end
    send(32'h00000063, 32'hFFFFFFFE, IMM_B);
    checks++; if (bus.out_instr !== 32'hFE000FE3 || bus.out_err !== 1'b0) begin failures++; $display("FAIL b_neg got=%h/%b exp=fe000fe3/0", bus.out_instr, bus.out_err); end
    checks++; if (enc_count !== 16'd3 || err_count !== 16'd2) begin failures++; $display("FAIL b_counts got=%0d/%0d exp=3/2", enc_count, err_count); end
  endtask

  task automatic test_j_format();
    send(32'h0000006F, 32'h00000800, IMM_J);
    checks++; if (bus.out_instr !== 32'h0010006F || bus.out_err !== 1'b0) begin failures++; $display("FAIL j_fmt got=%h/%b exp=0010006f/0", bus.out_instr, bus.out_err); end
    send(32'h0000006F, 32'h00100000, IMM_J);
    checks++; if (bus.out_instr !== 32'h8000006F || bus.out_err !== 1'b1) begin failures++; $display("FAIL j_over got=%h/%b exp=8000006f/1", bus.out_instr, bus.out_err); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_base = 32'h00000013;
    bus.in_imm_src = IMM_I;
    bus.in_imm = 32'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_instr !== 32'h00100013) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/00100013", bus.in_ready, bus.out_instr); end
    bus.in_imm = 32'd2;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_full got=%b/%b exp=0/1", bus.in_ready, bus.out_valid); end
    bus.in_imm = 32'd3;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || bus.out_instr !== 32'h00100013) begin failures++; $display("FAIL bp_hold got=%b/%h exp=0/00100013", bus.in_ready, bus.out_instr); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_instr !== 32'h00200013 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_pop1 got=%h/%b exp=00200013/1", bus.out_instr, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_instr !== 32'h00300013 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_pop2 got=%h/%b exp=00300013/1", bus.out_instr, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    clear();
    bus.out_ready = 1'b0;
    bus.in_imm = 32'd5;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (enc_count !== 16'd2 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL rm_pre got=%0d/%b exp=2/0", enc_count, bus.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_instr !== 32'h0) begin failures++; $display("FAIL rm_out got=%b/%b/%h exp=0/1/0", bus.out_valid, bus.in_ready, bus.out_instr); end
    checks++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin failures++; $display("FAIL rm_counts got=%0d/%0d exp=0/0", enc_count, err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_after got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_counters();
    clear();
    bus.in_base = 32'h00000013;
    bus.in_imm_src = IMM_I;
    bus.in_imm = 32'h00000800;
    bus.in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    checks++; if (enc_count !== 16'hFFFF || err_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat got=%h/%h exp=ffff/ffff", enc_count, err_count); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checks++; if (enc_count !== 16'h0 || err_count !== 16'h0) begin failures++; $display("FAIL cnt_clr got=%h/%h exp=0/0", enc_count, err_count); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (enc_count !== 16'd1 || err_count !== 16'd1) begin failures++; $display("FAIL cnt_resume got=%0d/%0d exp=1/1", enc_count, err_count); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_imm = '0;
    bus.in_imm_src = IMM_I;
    bus.in_base = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_i_format();
    test_s_format();
    test_b_format();
    test_j_format();
    test_backpressure();
    test_reset_mid();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
